// File: rtl/redirect_ctrl.sv
// redirect_ctrl: fetch-PC sequencing for EX-stage branch/jump redirects with
// IF/ID and ID/EX squash, pending-target hold while imem is busy, and
// misaligned-target filtering.
// Ports: clk, reset (async, active-low); ex_valid/ex_taken/ex_target from EX;
// fetch_pc_plus4, stall_req, fetch_ready; outputs pc_we/pc_next,
// flush_if_id/flush_id_ex, redirect_pending, misalign_err, stat_redirects,
// stat_wait_cycles.
// Optional: define REDIRECT_STATS_EN to build the redirect/wait counters.
module redirect_ctrl #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_taken,
  input  logic [31:0]     ex_target,
  input  logic [PC_W-1:0] fetch_pc_plus4,
  input  logic            stall_req,
  input  logic            fetch_ready,
  output logic            pc_we,
  output logic [PC_W-1:0] pc_next,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            redirect_pending,
  output logic            misalign_err,
  output logic [31:0]     stat_redirects,
  output logic [31:0]     stat_wait_cycles
);
  typedef enum logic [1:0] {RUN, WAIT, SHADOW} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] target, ex_pc, next_c;
  logic taken, aligned, redir, seq_ok, we_c, fi_c, fe_c, pend_c, unused_hi;
  assign ex_pc     = ex_target[PC_W-1:0];
  assign unused_hi = ^ex_target[31:PC_W];
  assign taken     = ex_valid & ex_taken & (state == RUN);
  assign aligned   = ex_target[1:0] == 2'b00;
  assign redir     = taken & aligned;
  assign seq_ok    = ~stall_req & fetch_ready;
  // A redirect outranks stall_req: the stalled ID instruction is wrong-path.
  always_comb begin
    state_nx = state;
    we_c     = seq_ok;
    next_c   = fetch_pc_plus4;
    fi_c     = 1'b0;
    fe_c     = 1'b0;
    pend_c   = 1'b0;
    case (state)
      RUN: if (redir) begin
        we_c     = fetch_ready;
        next_c   = ex_pc;
        fi_c     = 1'b1;
        fe_c     = 1'b1;
        state_nx = fetch_ready ? SHADOW : WAIT;
      end
      WAIT: begin
        we_c     = fetch_ready;
        next_c   = target;
        fi_c     = 1'b1;
        pend_c   = 1'b1;
        state_nx = fetch_ready ? SHADOW : WAIT;
      end
      SHADOW: state_nx = RUN;
      default: begin
        we_c     = 1'b0;
        state_nx = RUN;
      end
    endcase
  end
  // Combinational outputs are held at zero for as long as reset is low.
  assign pc_we            = reset & we_c;
  assign pc_next          = reset ? next_c : '0;
  assign flush_if_id      = reset & fi_c;
  assign flush_id_ex      = reset & fe_c;
  assign redirect_pending = reset & pend_c;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      target       <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nx;
      if (redir & ~fetch_ready) target <= ex_pc;
      misalign_err <= taken & ~aligned;
    end
  end
`ifdef REDIRECT_STATS_EN
  logic redir_wr;
  assign redir_wr = we_c & ((state == WAIT) | redir);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_redirects   <= '0;
      stat_wait_cycles <= '0;
    end else begin
      stat_redirects   <= stat_redirects + {31'd0, redir_wr};
      stat_wait_cycles <= stat_wait_cycles + {31'd0, state == WAIT};
    end
  end
`else
  assign stat_redirects   = '0;
  assign stat_wait_cycles = '0;
`endif
endmodule

// File: tb/tb_redirect_ctrl.sv
// tb_redirect_ctrl: directed scenarios plus randomized run against a reference model.
module tb_redirect_ctrl;
  localparam int PC_W = 9;
`ifdef REDIRECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, ex_valid, ex_taken, stall_req, fetch_ready;
  logic [31:0] ex_target;
  logic [PC_W-1:0] fetch_pc_plus4, pc_next;
  logic pc_we, flush_if_id, flush_id_ex, redirect_pending, misalign_err;
  logic [31:0] stat_redirects, stat_wait_cycles;
  int n_tests = 0;
  int n_fail = 0;
  redirect_ctrl #(.PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_taken(ex_taken),
    .ex_target(ex_target), .fetch_pc_plus4(fetch_pc_plus4), .stall_req(stall_req),
    .fetch_ready(fetch_ready), .pc_we(pc_we), .pc_next(pc_next),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .redirect_pending(redirect_pending), .misalign_err(misalign_err),
    .stat_redirects(stat_redirects), .stat_wait_cycles(stat_wait_cycles)
  );
  // Packed view: {pc_we, pc_next, flush_if_id, flush_id_ex, redirect_pending, misalign_err}
  function automatic logic [PC_W+4:0] pk(input logic we, input logic [PC_W-1:0] nx,
      input logic fi, input logic fe, input logic pd, input logic ms);
    return {we, nx, fi, fe, pd, ms};
  endfunction
  wire [PC_W+4:0] obs = {pc_we, pc_next, flush_if_id, flush_id_ex, redirect_pending, misalign_err};
  task automatic drive(input logic v, input logic t, input logic [31:0] tg,
      input logic [PC_W-1:0] p4, input logic st, input logic fr);
    ex_valid = v; ex_taken = t; ex_target = tg; fetch_pc_plus4 = p4;
    stall_req = st; fetch_ready = fr;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    tick();
    reset = 1'b1;
  endtask
  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1, 1, 32'h40, 9'h004, 0, 1);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (obs !== pk(0, 0, 0, 0, 0, 0) || stat_redirects !== 0 || stat_wait_cycles !== 0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h / %0d / %0d, want all zero", obs, stat_redirects, stat_wait_cycles);
      end
      tick();
    end
    reset = 1'b1;
    drive(0, 0, 0, 9'h004, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h004, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs, pk(1, 9'h004, 0, 0, 0, 0));
    end
    tick();
  endtask
  task automatic test_redirect_fast();
    do_reset();
    drive(1, 1, 32'h40, 9'h008, 1, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h040, 1, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL fast_redirect: got %h want %h", obs, pk(1, 9'h040, 1, 1, 0, 0));
    end
    tick();
    drive(1, 1, 32'h80, 9'h044, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h044, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL shadow_ignore: got %h want %h", obs, pk(1, 9'h044, 0, 0, 0, 0));
    end
    tick();
    drive(0, 0, 0, 9'h048, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h048, 0, 0, 0, 0) || stat_redirects !== (STATS ? 32'd1 : 32'd0)) begin
      n_fail++;
      $display("FAIL after_shadow: got %h redirects %0d", obs, stat_redirects);
    end
    tick();
  endtask
  task automatic test_redirect_wait();
    do_reset();
    drive(1, 1, 32'h40, 9'h008, 0, 0);
    #1;
    n_tests++;
    if (obs !== pk(0, 9'h040, 1, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL wait_resolve: got %h want %h", obs, pk(0, 9'h040, 1, 1, 0, 0));
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'h80, 9'h00c, 1, 0);
      #1;
      n_tests++;
      if ({pc_we, flush_if_id, flush_id_ex, redirect_pending} !== 4'b0101) begin
        n_fail++;
        $display("FAIL wait_hold%0d: got we/fi/fe/pd %b want 0101", i, {pc_we, flush_if_id, flush_id_ex, redirect_pending});
      end
      tick();
    end
    drive(0, 0, 0, 9'h00c, 1, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h040, 1, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL wait_release: got %h want %h", obs, pk(1, 9'h040, 1, 0, 1, 0));
    end
    tick();
    drive(1, 1, 32'h100, 9'h044, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h044, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL wait_shadow: got %h want %h", obs, pk(1, 9'h044, 0, 0, 0, 0));
    end
    n_tests++;
    if (stat_redirects !== (STATS ? 32'd1 : 32'd0) || stat_wait_cycles !== (STATS ? 32'd3 : 32'd0)) begin
      n_fail++;
      $display("FAIL wait_stats: got redirects %0d wait %0d", stat_redirects, stat_wait_cycles);
    end
    tick();
  endtask
  task automatic test_misalign();
    do_reset();
    drive(1, 1, 32'h42, 9'h008, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h008, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL misalign_cycle: got %h want %h", obs, pk(1, 9'h008, 0, 0, 0, 0));
    end
    tick();
    drive(0, 0, 0, 9'h00c, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h00c, 0, 0, 0, 1)) begin
      n_fail++;
      $display("FAIL misalign_pulse: got %h want %h", obs, pk(1, 9'h00c, 0, 0, 0, 1));
    end
    tick();
    n_tests++;
    if (misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_clear: got %b want 0", misalign_err);
    end
  endtask
  task automatic test_truncate();
    do_reset();
    drive(1, 1, 32'hFFFFFE80, 9'h008, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h080, 1, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL truncate: got %h want %h", obs, pk(1, 9'h080, 1, 1, 0, 0));
    end
    tick();
  endtask
  task automatic test_reset_in_wait();
    do_reset();
    drive(1, 1, 32'h40, 9'h008, 0, 0);
    tick();
    drive(0, 0, 0, 9'h008, 0, 0);
    #1;
    n_tests++;
    if (redirect_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_pending: got %b want 1", redirect_pending);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (obs !== pk(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL rw_async: got %h want 0", obs);
    end
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 9'h00c, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h00c, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL rw_release: got %h want %h", obs, pk(1, 9'h00c, 0, 0, 0, 0));
    end
    tick();
    drive(0, 0, 0, 9'h010, 0, 1);
    #1;
    n_tests++;
    if (obs !== pk(1, 9'h010, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL rw_no_target: got %h want %h", obs, pk(1, 9'h010, 0, 0, 0, 0));
    end
    tick();
  endtask
  // Reference model: a held target flag, a one-cycle shadow flag, and event counts.
  task automatic test_random();
    bit m_pend, m_shadow, m_mis;
    logic [PC_W-1:0] m_tgt;
    int unsigned m_sr, m_sw;
    do_reset();
    m_pend = 0; m_shadow = 0; m_mis = 0; m_tgt = '0; m_sr = 0; m_sw = 0;
    for (int i = 0; i < 500; i++) begin
      logic [31:0] t;
      logic e_we, e_fi, e_fe, e_pd, e_ms, taken_ok, redirect;
      logic [PC_W-1:0] e_nx;
      logic [31:0] e_sr, e_sw;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      reset = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, t, PC_W'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      #1;
      taken_ok = !m_pend && !m_shadow && ex_valid && ex_taken;
      redirect = taken_ok && (ex_target % 4 == 0);
      e_we = 0; e_nx = '0; e_fi = 0; e_fe = 0; e_pd = 0;
      if (reset) begin
        if (m_pend) begin
          e_pd = 1; e_fi = 1; e_we = fetch_ready; e_nx = m_tgt;
        end else if (redirect) begin
          e_fi = 1; e_fe = 1; e_we = fetch_ready; e_nx = PC_W'(ex_target % (1 << PC_W));
        end else begin
          e_we = !stall_req && fetch_ready; e_nx = fetch_pc_plus4;
        end
      end
      e_ms = reset && m_mis;
      e_sr = (reset && STATS) ? m_sr : 0;
      e_sw = (reset && STATS) ? m_sw : 0;
      n_tests++;
      if ({pc_we, flush_if_id, flush_id_ex, redirect_pending, misalign_err} !== {e_we, e_fi, e_fe, e_pd, e_ms}) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got we/fi/fe/pd/ms %b want %b", i,
                 {pc_we, flush_if_id, flush_id_ex, redirect_pending, misalign_err}, {e_we, e_fi, e_fe, e_pd, e_ms});
      end
      if (e_we || !reset) begin
        n_tests++;
        if (pc_next !== e_nx) begin
          n_fail++;
          $display("FAIL rand_pc[%0d]: got %h want %h", i, pc_next, e_nx);
        end
      end
      n_tests++;
      if (stat_redirects !== e_sr || stat_wait_cycles !== e_sw) begin
        n_fail++;
        $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d", i, stat_redirects, stat_wait_cycles, e_sr, e_sw);
      end
      tick();
      if (!reset) begin
        m_pend = 0; m_shadow = 0; m_mis = 0; m_tgt = '0; m_sr = 0; m_sw = 0;
      end else begin
        m_sr += (e_we && (m_pend || redirect)) ? 1 : 0;
        m_sw += m_pend ? 1 : 0;
        m_mis = taken_ok && (ex_target % 4 != 0);
        if (m_pend) begin
          if (fetch_ready) begin m_pend = 0; m_shadow = 1; end
        end else if (redirect) begin
          if (fetch_ready) m_shadow = 1;
          else begin m_pend = 1; m_tgt = PC_W'(ex_target % (1 << PC_W)); end
        end else m_shadow = 0;
      end
    end
  endtask
  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_redirect_fast();
    test_redirect_wait();
    test_misalign();
    test_truncate();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
